// File: rtl/dst_drain.sv
`default_nettype none
// ============================================================================
// Module   : dst_drain
// Purpose  : Read-side controller for the double-banked dst buffer. Streams
//            each finished 64-word bank out on a valid/ready master port and
//            hands banks back to the writer.
// Revision : 1.0 - initial release
// ============================================================================
module dst_drain #(
    parameter int DW    = 32,
    parameter int AW    = 6,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          out_fin,
    output logic          wr_bank,
    output logic          dst_full,
    output logic          rd_en,
    output logic [AW:0]   rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          drain_busy,
    output logic          blk_done,
    output logic          err
);

    localparam logic [AW:0] c_BLK_LEN  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_LAST_ADR = {1'b0, {AW{1'b1}}};
    localparam logic [1:0]  c_DEPTH    = 2'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_pend;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [AW:0]     r_issued;
    logic            r_inflight;
    logic            r_inflight_last;
    logic [1:0]      r_occ;
    logic            r_wptr;
    logic            r_rptr;
    logic [DW-1:0]   r_fifo_data [2];
    logic [1:0]      r_fifo_last;
    logic            r_err;
    logic            r_blk_done;

    logic            w_full;
    logic            w_valid;
    logic            w_pop;
    logic            w_last_hs;
    logic            w_accept;
    logic [1:0]      w_load;
    logic            w_room;
    logic            w_rd_en;
    logic [1:0]      w_set;
    logic [1:0]      w_clr;

    assign w_full    = r_pend[0] & r_pend[1];
    assign w_valid   = (r_occ != 2'd0);
    assign w_pop     = w_valid & m_ready;
    assign w_last_hs = w_pop & r_fifo_last[r_rptr];
    assign w_accept  = out_fin & ~w_full;
    // Reads in flight plus buffered words, after this cycle's pop
    assign w_load    = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_room    = (w_load < c_DEPTH);
    assign w_set     = w_accept  ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr     = w_last_hs ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend[r_rd_bank]) begin
                    w_rd_en     = w_room;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_rd_en = (r_issued != c_BLK_LEN) & w_room;
                // Chain straight into the other bank when it is already waiting
                if (w_last_hs) begin
                    w_state_nxt = r_pend[~r_rd_bank] ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend          <= 2'b00;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_occ           <= 2'd0;
            r_wptr          <= 1'b0;
            r_rptr          <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= 2'b00;
            r_err           <= 1'b0;
            r_blk_done      <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_clr) | w_set;
            r_blk_done <= w_last_hs;
            if (w_accept) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (out_fin & w_full) begin
                r_err <= 1'b1;
            end
            if (w_last_hs) begin
                r_rd_bank <= ~r_rd_bank;
                r_issued  <= '0;
            end else if (w_rd_en) begin
                r_issued <= r_issued + 1'b1;
            end
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en & (r_issued == c_LAST_ADR);
            if (r_inflight) begin
                r_fifo_data[r_wptr] <= rd_data;
                r_fifo_last[r_wptr] <= r_inflight_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign wr_bank    = r_wr_bank;
    assign dst_full   = w_full;
    assign rd_en      = w_rd_en;
    assign rd_addr    = {r_rd_bank, r_issued[AW-1:0]};
    assign m_valid    = w_valid;
    assign m_data     = r_fifo_data[r_rptr];
    assign m_last     = w_valid & r_fifo_last[r_rptr];
    assign drain_busy = (r_state == S_RUN) | w_valid;
    assign blk_done   = r_blk_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dst_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_dst_drain
// Purpose  : Self-checking bench for dst_drain: timing table, corner-case
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dst_drain;

    logic        clk;
    logic        rst_n;
    logic        out_fin;
    logic        wr_bank;
    logic        dst_full;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        drain_busy;
    logic        blk_done;
    logic        err;

    dst_drain #(.DW(32), .AW(6), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_fin    (out_fin),
        .wr_bank    (wr_bank),
        .dst_full   (dst_full),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .drain_busy (drain_busy),
        .blk_done   (blk_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer contents, one-cycle read latency
    logic [31:0] bufm [128];
    always @(posedge clk) rd_data <= rd_en ? bufm[rd_addr] : 32'h0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending-block count, writer bank, expected beats/addresses
    int          m_pend;
    logic        m_wr;
    logic        m_err;
    logic        m_bd;
    logic [32:0] exp_q [$];
    logic [6:0]  addr_q [$];
    int          n_iss, n_pop;
    logic        p_v, p_r;
    logic [32:0] p_d;

    task automatic model_reset();
        m_pend = 0; m_wr = 1'b0; m_err = 1'b0; m_bd = 1'b0;
        exp_q.delete(); addr_q.delete();
        n_iss = 0; n_pop = 0; p_v = 1'b0; p_r = 1'b0; p_d = '0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic rel;
        logic [32:0] e;
        if (!rst_n) begin
            model_reset();
        end else begin
            rel = 1'b0;
            chk("wr_bank", wr_bank, m_wr);
            chk("dst_full", dst_full, m_pend == 2);
            chk("err", err, m_err);
            chk("blk_done", blk_done, m_bd);
            if (exp_q.size() == 0) chk("idle_outputs", {drain_busy, m_valid, rd_en}, 3'b000);
            else if (m_valid) chk("busy_when_valid", drain_busy, 1'b1);
            if (rd_en) begin
                n_iss++;
                if (addr_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL rd_addr: unexpected read at %0h, expected none", rd_addr);
                end else begin
                    chk("rd_addr", rd_addr, addr_q.pop_front());
                end
            end
            if (p_v && !p_r) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", {m_last, m_data}, p_d);
            end
            if (m_valid && m_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL beat: extra beat %0h, expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_last, m_data}, e);
                    rel = e[32];
                end
            end
            chk("outstanding", (n_iss - n_pop) <= 2, 1'b1);
            p_v = m_valid; p_r = m_ready; p_d = {m_last, m_data};
            m_bd = rel;
            if (out_fin) begin
                if (m_pend == 2) begin
                    m_err = 1'b1;
                end else begin
                    for (int i = 0; i < 64; i++) begin
                        exp_q.push_back({i == 63, bufm[{m_wr, 6'(i)}]});
                        addr_q.push_back({m_wr, 6'(i)});
                    end
                    m_pend++;
                    m_wr = ~m_wr;
                end
            end
            if (rel) m_pend--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic bank, input logic [31:0] base);
        for (int i = 0; i < 64; i++) bufm[{bank, 6'(i)}] = base + 32'(i);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wr_bank"}, wr_bank, 0);
        chk({tag, "_dst_full"}, dst_full, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_drain_busy"}, drain_busy, 0);
        chk({tag, "_blk_done"}, blk_done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic drain(input int bound, input int pct);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            out_fin = 1'b0;
            m_ready = ($urandom_range(0, 99) < pct);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
        end
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    typedef struct {
        int          cyc;
        logic        rd_en;
        logic        mv;
        logic        ml;
        logic        bd;
        logic        busy;
        logic [31:0] dat;
    } vec_t;

    vec_t        tv [11];
    logic        lg_rd [72];
    logic        lg_v [72];
    logic        lg_l [72];
    logic        lg_bd [72];
    logic        lg_busy [72];
    logic [31:0] lg_d [72];

    initial begin
        int beats, lasts, rise, fall, last0, rd1, nrd;
        logic fin;

        tv[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tv[2]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tv[3]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100};
        tv[4]  = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h101};
        tv[5]  = '{34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11F};
        tv[6]  = '{64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13D};
        tv[7]  = '{65, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13E};
        tv[8]  = '{66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h13F};
        tv[9]  = '{67, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[10] = '{68, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0; out_fin = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 128; i++) bufm[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // T1: single block, sink always ready, cycle-exact timing
        fill(1'b0, 32'h100);
        for (int c = 0; c < 72; c++) begin
            tick();
            out_fin = (c == 0);
            m_ready = 1'b1;
            @(negedge clk);
            lg_rd[c] = rd_en; lg_v[c] = m_valid; lg_l[c] = m_last;
            lg_bd[c] = blk_done; lg_busy[c] = drain_busy; lg_d[c] = m_data;
        end
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("t1_rd_en_c%0d", tv[k].cyc), lg_rd[tv[k].cyc], tv[k].rd_en);
            chk($sformatf("t1_valid_c%0d", tv[k].cyc), lg_v[tv[k].cyc], tv[k].mv);
            chk($sformatf("t1_last_c%0d", tv[k].cyc), lg_l[tv[k].cyc], tv[k].ml);
            chk($sformatf("t1_blk_done_c%0d", tv[k].cyc), lg_bd[tv[k].cyc], tv[k].bd);
            chk($sformatf("t1_busy_c%0d", tv[k].cyc), lg_busy[tv[k].cyc], tv[k].busy);
            if (tv[k].mv) chk($sformatf("t1_data_c%0d", tv[k].cyc), lg_d[tv[k].cyc], tv[k].dat);
        end
        beats = 0; lasts = 0;
        for (int c = 3; c <= 66; c++) beats += lg_v[c];
        for (int c = 0; c < 72; c++) lasts += lg_l[c];
        chk("t1_gapfree_beats", beats, 64);
        chk("t1_last_count", lasts, 1);
        drain(100, 100);

        // T2: same data from bank 1 with a 50% ready sink
        fill(1'b1, 32'h100);
        tick();
        out_fin = 1'b1;
        m_ready = $urandom_range(0, 1);
        drain(1000, 50);

        // T3/T4: back-to-back blocks, then an out_fin while both banks pending
        fill(1'b0, 32'h200);
        fill(1'b1, 32'h300);
        rise = -1; fall = -1; last0 = -1; rd1 = -1;
        for (int c = 0; c < 140; c++) begin
            tick();
            out_fin = (c == 0 || c == 10 || c == 20);
            m_ready = 1'b1;
            @(negedge clk);
            if (dst_full && rise < 0) rise = c;
            if (m_valid && m_ready && m_last && last0 < 0) last0 = c;
            if (rd_en && rd_addr[6] && rd1 < 0) rd1 = c;
            if (rise >= 0 && last0 >= 0 && !dst_full && fall < 0) fall = c;
            if (c == 20) chk("t4_err_before", err, 0);
            if (c == 21) begin
                chk("t4_err_set", err, 1);
                chk("t4_wr_bank_kept", wr_bank, 0);
                chk("t4_still_full", dst_full, 1);
            end
        end
        chk("t3_full_rise", rise, 11);
        chk("t3_block0_last", last0, 66);
        chk("t3_full_fall", fall, last0 + 1);
        chk("t3_bank1_first_read", rd1, last0 + 1);
        drain(400, 100);
        chk("t4_err_sticky", err, 1);

        // T5: sink stalls for 20 cycles from the first beat
        fill(1'b0, 32'h100);
        nrd = 0;
        for (int c = 0; c <= 22; c++) begin
            tick();
            out_fin = (c == 0);
            m_ready = (c < 3);
            @(negedge clk);
            if (rd_en) nrd++;
            if (c == 22) begin
                chk("t5_valid_held", m_valid, 1);
                chk("t5_data_held", m_data, 32'h100);
            end
        end
        chk("t5_reads_issued", nrd, 2);
        drain(400, 100);

        // T6: reset in the middle of a block, then a fresh block into bank 0
        for (int i = 0; i < 64; i++) bufm[{1'b1, 6'(i)}] = $urandom;
        tick();
        out_fin = 1'b1;
        m_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 200 && beats < 30; i++) begin
            tick();
            out_fin = 1'b0;
            @(negedge clk);
            if (m_valid && m_ready) beats++;
        end
        chk("t6_reached_beat30", beats, 30);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_wr_bank_after", wr_bank, 0);
        fill(1'b0, 32'h500);
        tick();
        out_fin = 1'b1;
        drain(400, 100);

        // Randomized traffic: random sink stalls and writer completions
        for (int c = 0; c < 3000; c++) begin
            tick();
            m_ready = ($urandom_range(0, 99) < ((c < 1500) ? 50 : 85));
            fin = 1'b0;
            if (m_pend < 2 && $urandom_range(0, 39) == 0) begin
                for (int i = 0; i < 64; i++) bufm[{m_wr, 6'(i)}] = $urandom;
                fin = 1'b1;
            end else if (m_pend == 2 && $urandom_range(0, 199) == 0) begin
                fin = 1'b1;
            end
            out_fin = fin;
        end
        drain(2000, 75);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
